// File: rtl/lsu_mem_initiator.sv
// LSU memory initiator: CPU load/store requests to a single-port byte memory.
// Sub-word stores use read-modify-write; illegal accesses answer with resp_err.
module lsu_mem_initiator #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter logic [31:0] MEM_TOP       = 32'h0001FFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [31:0]              mem_wd,
  input  logic [31:0]              mem_rd
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  state_t                   state;
  logic [2:0]               funct3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [31:0]              wdata_q;
  logic [31:0]              merge;
  logic                     bad;

  // Range check in 64 bits so addresses near the top never wrap.
  always_comb begin
    bad = 1'b0;
    if (req_store)
      bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      bad = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      bad = 1'b1;
    if (64'(req_addr) + 64'd3 > 64'(MEM_TOP))
      bad = 1'b1;
  end

  function automatic logic [31:0] fmt(
    input logic [2:0]  f,
    input logic [31:0] d
  );
    logic [31:0] r;
    case (f)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b100:  r = {24'h0, d[7:0]};
      3'b101:  r = {16'h0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      merge      <= 32'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (!req_store) begin
              state <= LOAD;
            end else if (req_funct3[1]) begin
              state <= STORE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= fmt(funct3_q, mem_rd);
        end
        STORE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RMW_RD: begin
          merge <= mem_rd;
          state <= RMW_WR;
        end
        RMW_WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs decode straight from the state register so that
  // reset drops the write strobe without waiting for an edge.
  always_comb begin
    req_ready = (state == IDLE);
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_wd    = 32'h0;
    unique case (state)
      LOAD, RMW_RD: begin
        mem_a = addr_q;
      end
      STORE: begin
        mem_we = 1'b1;
        mem_a  = addr_q;
        mem_wd = wdata_q;
      end
      RMW_WR: begin
        mem_we = 1'b1;
        mem_a  = addr_q;
        if (funct3_q[0])
          mem_wd = {merge[31:16], wdata_q[15:0]};
        else
          mem_wd = {merge[31:8], wdata_q[7:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: byte memory model,
// vector table with scoreboard, plus backpressure and reset sequences.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  logic [31:0] last_wd = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_initiator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  logic [7:0] mem [0:131071];

  always_comb begin
    mem_rd = 32'h0;
    if (mem_a <= 32'h1FFFC)
      mem_rd = {mem[mem_a[16:0] + 17'd3], mem[mem_a[16:0] + 17'd2],
                mem[mem_a[16:0] + 17'd1], mem[mem_a[16:0]]};
  end

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt  = we_cnt + 1;
      last_wd = mem_wd;
      if (mem_a <= 32'h1FFFC)
        for (int i = 0; i < 4; i++)
          mem[mem_a[16:0] + 17'(i)] <= mem_wd[8*i +: 8];
    end
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];

  function automatic vec_t mk(
    input logic st, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
    input int lat, input int we, input logic [31:0] wd
  );
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat; v.we = we; v.wd = wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [16:0] a);
    return {mem[a + 17'd3], mem[a + 17'd2], mem[a + 17'd1], mem[a]};
  endfunction

  task automatic run(input vec_t v, input string nm);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = v.st;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    we_cnt     = 0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    sb.push_back('{v.rdata, v.err, v.lat});
    #1;
    // scramble inputs to show the access uses latched values
    req_valid  = 1'b0;
    req_store  = ~v.st;
    req_funct3 = 3'b111;
    req_addr   = 32'h0000_0104;
    req_wdata  = 32'h0F0F_0F0F;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 10);
    e = sb.pop_front();
    chk({nm, " latency"}, 32'(n), 32'(e.lat));
    chk({nm, " rdata"}, resp_rdata, e.rdata);
    chk({nm, " err"}, 32'(resp_err), 32'(e.err));
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({nm, " we_count"}, 32'(we_cnt), 32'(v.we));
    if (v.we != 0)
      chk({nm, " wd"}, last_wd, v.wd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[32'h100] = 8'h80; mem[32'h101] = 8'h22;
    mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    mem[32'h1FFFC] = 8'h01; mem[32'h1FFFD] = 8'h02;
    mem[32'h1FFFE] = 8'h03; mem[32'h1FFFF] = 8'h04;
    mem[32'h300] = 8'h11; mem[32'h301] = 8'h22;
    mem[32'h302] = 8'h33; mem[32'h303] = 8'h44;

    // reset state, with a request offered that must not be taken
    #1 rst_n = 1'b0;
    req_valid = 1'b1;
    req_store = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h100;
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst mem_wd", mem_wd, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst no accept", 32'(req_ready), 32'd1);
    chk("rst no write", 32'(we_cnt), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    vq.push_back(mk(0, 3'b000, 32'h100, 0, 32'hFFFFFF80, 0, 2, 0, 0));
    vq.push_back(mk(0, 3'b100, 32'h100, 0, 32'h00000080, 0, 2, 0, 0));
    vq.push_back(mk(0, 3'b010, 32'h100, 0, 32'h44332280, 0, 2, 0, 0));
    vq.push_back(mk(0, 3'b001, 32'h102, 0, 32'h00004433, 0, 2, 0, 0));
    vq.push_back(mk(0, 3'b000, 32'h103, 0, 32'h00000044, 0, 2, 0, 0));
    vq.push_back(mk(0, 3'b001, 32'h100, 0, 32'h00002280, 0, 2, 0, 0));
    vq.push_back(mk(1, 3'b000, 32'h100, 32'hAAAAAA5A, 0, 0, 3, 1, 32'h4433225A));
    vq.push_back(mk(0, 3'b010, 32'h100, 0, 32'h4433225A, 0, 2, 0, 0));
    vq.push_back(mk(1, 3'b001, 32'h101, 32'h1234, 0, 1, 1, 0, 0));
    vq.push_back(mk(0, 3'b010, 32'h1FFFC, 0, 32'h04030201, 0, 2, 0, 0));
    vq.push_back(mk(0, 3'b010, 32'h1FFFD, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(0, 3'b000, 32'h1FFFD, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(0, 3'b000, 32'h1FFFC, 0, 32'h00000001, 0, 2, 0, 0));
    vq.push_back(mk(0, 3'b011, 32'h100, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(1, 3'b010, 32'h200, 32'h12345678, 0, 0, 2, 1, 32'h12345678));
    vq.push_back(mk(0, 3'b001, 32'h202, 0, 32'h00001234, 0, 2, 0, 0));
    vq.push_back(mk(0, 3'b101, 32'h202, 0, 32'h00001234, 0, 2, 0, 0));
    vq.push_back(mk(1, 3'b001, 32'h200, 32'hFFFF9ABC, 0, 0, 3, 1, 32'h12349ABC));
    vq.push_back(mk(0, 3'b001, 32'h200, 0, 32'hFFFF9ABC, 0, 2, 0, 0));
    vq.push_back(mk(0, 3'b101, 32'h200, 0, 32'h00009ABC, 0, 2, 0, 0));
    vq.push_back(mk(0, 3'b010, 32'h200, 0, 32'h12349ABC, 0, 2, 0, 0));
    vq.push_back(mk(1, 3'b100, 32'h200, 32'h1, 0, 1, 1, 0, 0));
    vq.push_back(mk(0, 3'b010, 32'hFFFFFFFC, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(0, 3'b010, 32'h102, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(0, 3'b110, 32'h100, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(1, 3'b010, 32'h1FFFD, 32'h55, 0, 1, 1, 0, 0));

    foreach (vq[i]) run(vq[i], $sformatf("v%0d", i));

    // backpressure: response held for five cycles
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0;
    req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("bp load mem_a", mem_a, 32'h100);
    chk("bp load mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("bp resp_valid", 32'(resp_valid), 32'd1);
    chk("bp rdata", resp_rdata, 32'h4433225A);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d valid", c), 32'(resp_valid), 32'd1);
      chk($sformatf("bp hold%0d rdata", c), resp_rdata, 32'h4433225A);
      chk($sformatf("bp hold%0d req_ready", c), 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("bp idle req_ready", 32'(req_ready), 32'd1);
    chk("bp idle resp_valid", 32'(resp_valid), 32'd0);

    // reset dropped during RMW_WR suppresses the write
    @(negedge clk);
    we_cnt = 0;
    req_valid = 1'b1; req_store = 1'b1;
    req_funct3 = 3'b000; req_addr = 32'h300; req_wdata = 32'h000000EE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rr rmw_rd mem_we", 32'(mem_we), 32'd0);
    chk("rr rmw_rd mem_a", mem_a, 32'h300);
    @(posedge clk);
    #1;
    chk("rr rmw_wr mem_we", 32'(mem_we), 32'd1);
    chk("rr rmw_wr mem_wd", mem_wd, 32'h443322EE);
    rst_n = 1'b0;
    #1;
    chk("rr mem_we drop", 32'(mem_we), 32'd0);
    chk("rr mem_wd drop", mem_wd, 32'h0);
    chk("rr req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("rr no write", 32'(we_cnt), 32'd0);
    chk("rr mem intact", word_at(17'h300), 32'h44332211);
    @(negedge clk);
    rst_n = 1'b1;
    run(mk(0, 3'b010, 32'h300, 0, 32'h44332211, 0, 2, 0, 0), "post_rst lw");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
